// File: rtl/sdram_arbiter.sv
// Central SDRAM command-bus arbiter: init sequencer, write engine and read engine share the pins,
// and the arbiter owns the auto-refresh timer. Priority is refresh > write > read.
module sdram_arbiter #(
    parameter int REF_PERIOD = 780,
    parameter int TRFC       = 7,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init_done,
    input  logic [3:0]            init_cmd,
    input  logic [ADDR_WIDTH-1:0] init_addr,
    input  logic                  wr_rq,
    input  logic                  wr_end_flag,
    input  logic [3:0]            wr_cmd,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [1:0]            wr_bank_addr,
    output logic                  wr_en,
    input  logic                  rd_rq,
    input  logic                  rd_end_flag,
    input  logic [3:0]            rd_cmd,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [1:0]            rd_bank_addr,
    output logic                  rd_en,
    output logic                  ref_rq,
    output logic                  sdram_cke,
    output logic [3:0]            sdram_cmd,
    output logic [ADDR_WIDTH-1:0] sdram_addr,
    output logic [1:0]            sdram_bank
);

    localparam int RCW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
    localparam int ACW = (TRFC > 1) ? $clog2(TRFC) : 1;
    localparam logic [RCW-1:0] REF_LAST  = RCW'(REF_PERIOD - 1);
    localparam logic [ACW-1:0] AREF_LAST = ACW'(TRFC - 1);
    localparam logic [3:0]     CMD_NOP   = 4'b0111;
    localparam logic [3:0]     CMD_AREF  = 4'b0001;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_ARBIT = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } state_t;

    state_t         state_r;
    logic [RCW-1:0] ref_cnt_r;
    logic [ACW-1:0] aref_cnt_r;
    logic           ref_rq_r;
    logic           wr_en_r;
    logic           rd_en_r;
    logic           ref_wrap_s;
    logic           enter_aref_s;

    assign ref_wrap_s   = init_done && (ref_cnt_r == REF_LAST);
    assign enter_aref_s = (state_r == ST_ARBIT) && ref_rq_r;

    assign wr_en     = wr_en_r;
    assign rd_en     = rd_en_r;
    assign ref_rq    = ref_rq_r;
    assign sdram_cke = 1'b1;

    // Refresh timer, sticky refresh request and the arbitration state machine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_INIT;
            ref_cnt_r  <= '0;
            aref_cnt_r <= '0;
            ref_rq_r   <= 1'b0;
            wr_en_r    <= 1'b0;
            rd_en_r    <= 1'b0;
        end else begin
            wr_en_r <= 1'b0;
            rd_en_r <= 1'b0;

            if (!init_done || ref_wrap_s) begin
                ref_cnt_r <= '0;
            end else begin
                ref_cnt_r <= ref_cnt_r + 1'b1;
            end

            // Entering AREF services the request; a coincident wrap must not queue a second one.
            if (enter_aref_s) begin
                ref_rq_r <= 1'b0;
            end else if (ref_wrap_s) begin
                ref_rq_r <= 1'b1;
            end else begin
                ref_rq_r <= ref_rq_r;
            end

            case (state_r)
                ST_INIT: begin
                    if (init_done) begin
                        state_r <= ST_ARBIT;
                    end
                end
                ST_ARBIT: begin
                    if (ref_rq_r) begin
                        state_r    <= ST_AREF;
                        aref_cnt_r <= '0;
                    end else if (wr_rq) begin
                        state_r <= ST_WRITE;
                        wr_en_r <= 1'b1;
                    end else if (rd_rq) begin
                        state_r <= ST_READ;
                        rd_en_r <= 1'b1;
                    end else begin
                        state_r <= ST_ARBIT;
                    end
                end
                ST_AREF: begin
                    if (aref_cnt_r == AREF_LAST) begin
                        state_r    <= ST_ARBIT;
                        aref_cnt_r <= '0;
                    end else begin
                        aref_cnt_r <= aref_cnt_r + 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (wr_end_flag) begin
                        state_r <= ST_ARBIT;
                    end
                end
                ST_READ: begin
                    if (rd_end_flag) begin
                        state_r <= ST_ARBIT;
                    end
                end
                default: begin
                    state_r <= ST_INIT;
                end
            endcase
        end
    end

    // Pin mux: engines already drive registered cmd/addr, so they pass straight through.
    always_comb begin
        sdram_cmd  = CMD_NOP;
        sdram_addr = '0;
        sdram_bank = 2'b00;
        case (state_r)
            ST_INIT: begin
                sdram_cmd  = init_cmd;
                sdram_addr = init_addr;
                sdram_bank = 2'b00;
            end
            ST_ARBIT: begin
                sdram_cmd  = CMD_NOP;
                sdram_addr = '0;
                sdram_bank = 2'b00;
            end
            ST_AREF: begin
                sdram_cmd  = (aref_cnt_r == '0) ? CMD_AREF : CMD_NOP;
                sdram_addr = '0;
                sdram_bank = 2'b00;
            end
            ST_WRITE: begin
                sdram_cmd  = wr_cmd;
                sdram_addr = wr_addr;
                sdram_bank = wr_bank_addr;
            end
            ST_READ: begin
                sdram_cmd  = rd_cmd;
                sdram_addr = rd_addr;
                sdram_bank = rd_bank_addr;
            end
            default: begin
                sdram_cmd  = CMD_NOP;
                sdram_addr = '0;
                sdram_bank = 2'b00;
            end
        endcase
    end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Central SDRAM command arbiter between the power-up init sequencer, the write engine and the read engine.
- Owns the auto-refresh timer and issues AUTO REFRESH itself.
- Grants the SDRAM command/address bus to one source at a time. Priority: refresh > write > read.
- Muxes the granted source's cmd/addr/bank onto the SDRAM pins.

Parameters:
- REF_PERIOD, 780, clk cycles between refresh requests (7.8 us at 100 MHz).
- TRFC, 7, cycles the AREF state occupies, including the AREF command cycle.
- ADDR_WIDTH, 12, SDRAM address width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- init_done  in  1  init sequencer finished (level, stays 1)
- init_cmd  in  4  init command {cs_n,ras_n,cas_n,we_n}
- init_addr  in  ADDR_WIDTH  init address
- wr_rq  in  1  write engine requests the bus
- wr_end_flag  in  1  write engine released the bus (1-cycle pulse)
- wr_cmd  in  4  write engine command
- wr_addr  in  ADDR_WIDTH  write engine address
- wr_bank_addr  in  2  write engine bank
- wr_en  out  1  write grant, 1-cycle pulse
- rd_rq  in  1  read engine requests the bus
- rd_end_flag  in  1  read engine released the bus (1-cycle pulse)
- rd_cmd  in  4  read engine command
- rd_addr  in  ADDR_WIDTH  read engine address
- rd_bank_addr  in  2  read engine bank
- rd_en  out  1  read grant, 1-cycle pulse
- ref_rq  out  1  refresh pending; engines must yield at the next burst boundary
- sdram_cke  out  1  clock enable
- sdram_cmd  out  4  command to pins
- sdram_addr  out  ADDR_WIDTH  address to pins
- sdram_bank  out  2  bank to pins

Behaviour:
- Reset:
  - rst_n is asynchronous, active-low; clock is clk.
  - State = INIT.
  - wr_en, rd_en, ref_rq = 0; sdram_cke = 1.
  - Refresh counter = 0, AREF counter = 0.
- Command encodings: NOP = 4'b0111, AREF = 4'b0001.
- States: INIT, ARBIT, AREF, WRITE, READ (registered FSM).
- INIT:
  - Pins = init_cmd/init_addr, bank = 0.
  - Goes to ARBIT in the cycle after init_done is sampled 1.
- ARBIT:
  - Pins = NOP, addr 0, bank 0.
  - Evaluated each cycle in priority order:
    1. ref_rq = 1 -> AREF.
    2. Else wr_rq = 1 -> WRITE; wr_en = 1 for exactly the first cycle in WRITE.
    3. Else rd_rq = 1 -> READ; rd_en = 1 for exactly the first cycle in READ.
    4. Else stay in ARBIT.
- WRITE:
  - Pins = wr_cmd/wr_addr/wr_bank_addr, combinational mux from the write engine's registered outputs (zero added latency).
  - Returns to ARBIT the cycle after wr_end_flag = 1.
  - rd_rq and ref_rq do not preempt; the write engine yields on ref_rq itself.
- READ: mirrors WRITE, using rd_* signals and rd_end_flag.
- AREF:
  - Entry cycle: pins = AREF, addr 0.
  - Remaining cycles: NOP.
  - Exits to ARBIT when aref_cnt == TRFC-1, i.e. TRFC cycles total.
- Refresh timer:
  - Held at 0 while init_done = 0.
  - Otherwise counts 0..REF_PERIOD-1 and wraps.
  - At the wrap, ref_rq is set (sticky).
  - ref_rq clears on the clock edge that enters AREF.
  - Timer free-runs through AREF/WRITE/READ.
  - A wrap while ref_rq is already 1 leaves it at 1; no second refresh is queued.
- Ignored inputs:
  - wr_end_flag/rd_end_flag outside their own grant state.
  - wr_rq/rd_rq during INIT.
- Simultaneous wr_rq & rd_rq in ARBIT -> WRITE; the read waits, so each engine must hold its rq until granted.
- End flag and new rq in the same cycle: back to ARBIT first; the new grant is at least 1 cycle later. ARBIT always lasts at least 1 cycle between grants.
- Reset mid-operation: everything returns to reset values asynchronously; init must re-run.

Test Plan:
- Reset, init_done low 20 cycles, init_cmd = 4'b0010 -> sdram_cmd = 0010 throughout. init_done = 1 -> ARBIT next cycle, cmd = 0111.
- After init, no requests for REF_PERIOD cycles -> ref_rq rises. Next cycle cmd = 0001 for 1 cycle, then 6 NOP cycles, then ARBIT, with ref_rq = 0.
- wr_rq = 1 in ARBIT -> wr_en pulses 1 cycle. sdram_cmd tracks wr_cmd (0011, 0100, 0111 sequence) until 1 cycle after wr_end_flag.
- wr_rq and rd_rq asserted together -> write granted first. After wr_end_flag, ARBIT 1 cycle, then rd_en pulse.
- Refresh timer wraps mid-write -> ref_rq = 1, no preemption. Write engine ends (wr_end_flag), then AREF entered before the still-pending wr_rq/rd_rq.
- rst_n pulled low during READ -> outputs go to reset values immediately; state INIT until init_done is resampled.
